// File: rtl/fp_add_result_collector.sv
// Result collector for the fixed-latency single-precision adder.
// Tracks valid adder cycles, classifies sums, buffers them in a credit-throttled FIFO.
module fp_add_result_collector #(
  parameter int LATENCY = 5,
  parameter int DEPTH   = 4,
  parameter int CW      = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [31:0]   sum,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   res_data,
  output logic [3:0]    res_flags,
  output logic [CW-1:0] res_count,
  output logic [CW-1:0] inflight,
  output logic          busy
);
  localparam int AW = $clog2(DEPTH);

  logic [LATENCY-1:0] vld;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [CW-1:0]      fly;
  logic [35:0]        mem [DEPTH];
  logic [35:0]        last;
  logic [CW:0]        credit;
  logic [7:0]         ex;
  logic [22:0]        man;
  logic [3:0]         flags;
  logic               accept;
  logic               done;
  logic               full;
  logic               wr;
  logic               pop;

  assign ex  = sum[30:23];
  assign man = sum[22:0];
  assign flags = {
    ex == 8'hFF && man != '0,
    ex == 8'hFF && man == '0,
    ex == 8'h00 && man == '0,
    ex == 8'h00 && man != '0
  };

  // credit uses registered state only; a pop frees a slot next cycle
  assign credit      = {1'b0, fly} + {1'b0, count};
  assign issue_ready = credit < (CW+1)'(DEPTH);
  assign accept      = issue_valid & issue_ready;
  assign done        = vld[LATENCY-1];
  assign full        = count == CW'(DEPTH);
  assign wr          = done & ~full;
  assign res_valid   = count != '0;
  assign pop         = res_valid & res_ready;

  assign {res_flags, res_data} = res_valid ? mem[rd_ptr] : last;
  assign res_count = count;
  assign inflight  = fly;
  assign busy      = credit != '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      fly    <= '0;
      last   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      vld <= LATENCY'({vld, accept});
      if (wr) begin
        mem[wr_ptr] <= {flags, sum};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        last   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr && !pop)      count <= count + CW'(1);
      else if (!wr && pop) count <= count - CW'(1);
      if (accept && !done)      fly <= fly + CW'(1);
      else if (!accept && done) fly <= fly - CW'(1);
    end
  end

  no_write_when_full: assert property (
    @(posedge clk) disable iff (!reset) done |-> !full
  ) else $error("result written while FIFO full");

endmodule

// File: tb/tb_fp_add_result_collector.sv
// Bench for fp_add_result_collector: adder modelled as a delay line,
// outputs compared each cycle against a queue-based reference.
module tb_fp_add_result_collector;
  localparam int LATENCY = 5;
  localparam int DEPTH   = 4;
  localparam int CW      = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic [31:0]   sum = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [31:0]   res_data;
  logic [3:0]    res_flags;
  logic [CW-1:0] res_count;
  logic [CW-1:0] inflight;
  logic          busy;

  always #5 clk = ~clk;

  fp_add_result_collector #(
    .LATENCY(LATENCY), .DEPTH(DEPTH), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .sum(sum),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags),
    .res_count(res_count), .inflight(inflight),
    .busy(busy)
  );

  typedef struct {
    int          due;
    logic [31:0] d;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] fifo[$];
  int          cur_edge = 0;
  int          total = 0;
  int          bad = 0;
  int          n_acc = 0;

  function automatic logic [3:0] ref_flags(logic [31:0] v);
    int e;
    int m;
    e = int'(v[30:23]);
    m = int'(v[22:0]);
    return {e == 255 && m != 0, e == 255 && m == 0,
            e == 0 && m == 0, e == 0 && m != 0};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int m_credit();
    return pend.size() + fifo.size();
  endfunction

  task automatic check_model();
    chk("issue_ready", 32'(issue_ready), 32'(m_credit() < DEPTH));
    chk("res_valid", 32'(res_valid), 32'(fifo.size() > 0));
    chk("res_count", 32'(res_count), 32'(fifo.size()));
    chk("inflight", 32'(inflight), 32'(pend.size()));
    chk("busy", 32'(busy), 32'(m_credit() != 0));
    if (fifo.size() > 0) begin
      chk("res_data", res_data, fifo[0]);
      chk("res_flags", 32'(res_flags), 32'(ref_flags(fifo[0])));
    end
  endtask

  // one clock: compare at negedge, drive, advance model at posedge
  task automatic cycle(input logic iv, input logic rr,
                       input logic [31:0] data);
    logic acc;
    logic pop;
    logic wrq;
    int   pre;
    pend_t w;
    check_model();
    issue_valid = iv;
    res_ready   = rr;
    acc = iv && (m_credit() < DEPTH);
    @(posedge clk);
    pre = fifo.size();
    pop = pre > 0 && rr;
    wrq = pend.size() > 0 && pend[0].due == cur_edge;
    if (pop) void'(fifo.pop_front());
    if (wrq) begin
      w = pend.pop_front();
      if (pre < DEPTH) fifo.push_back(w.d);
    end
    if (acc) begin
      pend.push_back('{cur_edge + LATENCY, data});
      n_acc++;
    end
    cur_edge++;
    #1;
    if (pend.size() > 0 && pend[0].due == cur_edge) sum = pend[0].d;
    else sum = $urandom;
    @(negedge clk);
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((m_credit() != 0) && n < lim) begin
      cycle(1'b0, 1'b1, 32'h0);
      n++;
    end
    chk("drain_timeout", 32'(m_credit() != 0), 32'h0);
  endtask

  logic [3:0] flag_tab [4];
  logic [31:0] flag_in [4];

  initial begin
    int k;
    int n;
    flag_in  = '{32'h7F800000, 32'hFFC00000, 32'h80000000, 32'h00000001};
    flag_tab = '{4'b0100, 4'b1000, 4'b0010, 4'b0001};

    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      issue_valid = 1'($urandom);
      res_ready   = 1'($urandom);
      sum         = $urandom;
      #1;
      chk("rst_valid", 32'(res_valid), 32'h0);
      chk("rst_data", res_data, 32'h0);
      chk("rst_flags", 32'(res_flags), 32'h0);
      chk("rst_count", 32'(res_count), 32'h0);
      chk("rst_inflight", 32'(inflight), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ready", 32'(issue_ready), 32'h1);
    end
    @(negedge clk);
    issue_valid = 1'b0;
    reset = 1'b1;
    cycle(1'b0, 1'b0, 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // single issue latency
    cycle(1'b1, 1'b1, 32'h40400000);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'h0);
    chk("lat_early", 32'(res_valid), 32'h0);
    cycle(1'b0, 1'b1, 32'h0);
    chk("lat_valid", 32'(res_valid), 32'h1);
    chk("lat_data", res_data, 32'h40400000);
    chk("lat_flags", 32'(res_flags), 32'h0);
    cycle(1'b0, 1'b1, 32'h0);
    chk("lat_busy", 32'(busy), 32'h0);

    // back-pressure: credit caps accepts at DEPTH
    n_acc = 0;
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, $urandom);
    chk("bp_accepts", 32'(n_acc), 32'd4);
    chk("bp_count", 32'(res_count), 32'd4);
    chk("bp_ready", 32'(issue_ready), 32'h0);
    cycle(1'b0, 1'b1, 32'h0);
    chk("bp_credit", 32'(issue_ready), 32'h1);
    drain(20);

    // flag classification
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, flag_in[i]);
    k = 0;
    n = 0;
    while (k < 4 && n < 30) begin
      if (res_valid) begin
        chk("flag_lit", 32'(res_flags), 32'(flag_tab[k]));
        k++;
      end
      cycle(1'b0, 1'b1, 32'h0);
      n++;
    end
    chk("flag_seen", 32'(k), 32'd4);

    // concurrent write and pop at count 2
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, $urandom);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
    chk("wp_pre", 32'(res_count), 32'd2);
    cycle(1'b0, 1'b1, 32'h0);
    chk("wp_count", 32'(res_count), 32'd2);
    drain(20);

    // random stream of 11 results
    n_acc = 0;
    n = 0;
    while (n_acc < 11 && n < 400) begin
      cycle(1'($urandom), 1'($urandom), $urandom);
      n++;
    end
    chk("stream_acc", 32'(n_acc), 32'd11);
    drain(60);

    // asynchronous reset mid-flight
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, $urandom);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, $urandom);
    chk("mid_busy", 32'(busy), 32'h1);
    issue_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 32'(res_valid), 32'h0);
    chk("ar_count", 32'(res_count), 32'h0);
    chk("ar_inflight", 32'(inflight), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_ready", 32'(issue_ready), 32'h1);
    pend.delete();
    fifo.delete();
    #1 reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 32'h0);
    chk("ar_after", 32'(res_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
